minmax_seq_ctrl: RTL and testbench
==================================

Name: minmax_seq_ctrl

Overview:
Sequencer that streams a programmed-length burst of 4-bit samples through a shared magnitude-compare core and tracks the running maximum and minimum and their indices. Samples arrive over a valid/ready handshake. Results are presented with a one-cycle done pulse. Sits between a sample source, e.g. an ADC or register FIFO, and downstream threshold logic.

Parameters:
DATA_W, 4, sample width in bits
CNT_W, 8, width of the burst length and index registers; maximum burst length is 2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  start a burst; sampled only in IDLE
len  input  CNT_W  number of samples in the burst; captured on an accepted start
in_valid  input  1  sample valid
in_data  input  DATA_W  sample value
in_ready  output  1  block accepts a sample this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results are valid
empty  output  1  last burst had len=0; held with results
all_eq  output  1  every sample in the last burst was equal
max_val  output  DATA_W  largest sample
min_val  output  DATA_W  smallest sample
max_idx  output  CNT_W  index of the first occurrence of max_val
min_idx  output  CNT_W  index of the first occurrence of min_val

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0. The sample counter is 0.
- Handshake: a sample transfers on a clk edge with in_valid&&in_ready. in_ready depends only on state, never on in_valid.
- IDLE:
  - start=1 and len!=0 -> capture len, go to FIRST.
  - start=1 and len=0 -> go to DONE. Clear max/min/idx to 0, set empty=1, set all_eq=0.
  - start is ignored in every other state.
- FIRST: in_ready=1. On transfer:
  - max_val=min_val=in_data, max_idx=min_idx=0, cnt=1, all_eq=1, empty=0.
  - If len==1 go to DONE, else go to RUN.
- RUN: in_ready=1. On transfer, the core compares in_data against max_val and min_val.
  - gt vs max_val -> max_val=in_data, max_idx=cnt.
  - lt vs min_val -> min_val=in_data, min_idx=cnt.
  - Ties do not update, so the first occurrence is kept.
  - all_eq is cleared if in_data != max_val.
  - cnt increments. If cnt==len-1 at the transfer, go to DONE.
- DONE: done=1 for exactly one cycle, in_ready=0, busy=1. Next state is IDLE.
- Results hold their values from DONE until the FIRST-state load of the next burst, or until reset.
- Latency: done asserts the cycle after the last sample transfer.
  - A burst of len=N with in_valid held high takes N+2 cycles from the start edge to the done pulse.
- in_valid low in FIRST or RUN: stall with no state change and no timeout.
- Reset mid-burst: next state is IDLE with all outputs 0. The partial burst is discarded and no done pulse is produced.
- Arithmetic: comparisons are unsigned DATA_W-bit. The counter never wraps because len <= 2^CNT_W-1.

Optional Feature:
MINMAX_SIGNED_EN
- Defined: samples are two's complement. The core compares signed, so 4'b1000 (-8) is the minimum and 4'b0111 (+7) is the maximum.
- Undefined: unsigned compare as above.
- Ports and timing are identical in both builds.

Decomposition:
- Package minmax_pkg:
  - state enum {IDLE, FIRST, RUN, DONE}
  - DATA_W and CNT_W default constants
  - compare-result struct {eq, gt, lt}
- One sub-module, cmp4_core: purely combinational, parameterised by DATA_W. It produces eq/gt/lt and honours MINMAX_SIGNED_EN.
  - It is instantiated twice: sample vs max_val and sample vs min_val.
  - The FSM, counter and result registers live in minmax_seq_ctrl.

Test Plan:
- Basic burst: start with len=4 and samples 3,9,1,9 streamed back-to-back.
  - Expect max_val=9, max_idx=1, min_val=1, min_idx=2, all_eq=0.
  - Expect the done pulse 6 cycles after start.
- All equal: len=3 with samples 15,15,15 -> max_val=min_val=15, idx=0, all_eq=1.
- Empty burst: len=0.
  - Expect done on the cycle after start, empty=1, all results 0, in_ready never high.
- Stalls: len=2 with in_valid low for 5 cycles between the samples 5 and 2.
  - Expect no state change while stalled. Then max_val=5, min_val=2, min_idx=1, single done pulse.
- Reset mid-burst: len=5, assert rst after 2 samples.
  - Expect all outputs 0 and state IDLE next cycle, no done pulse.
  - A following len=1 burst with sample 7 yields max_val=min_val=7.
- Signed build (MINMAX_SIGNED_EN defined): samples 7,8,0.
  - Expect max_val=7, min_val=4'b1000.
  - The unsigned build gives max_val=8, min_val=0.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared types and default widths for the min/max burst sequencer.
// The compare core honours the MINMAX_SIGNED_EN build macro (signed samples).
package minmax_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_t;

  // The sample carrying index cnt is the last one of a burst of length len.
  function automatic logic is_last(input logic [CNT_W_DEF-1:0] cnt,
                                   input logic [CNT_W_DEF-1:0] len);
    return cnt == len - 1'b1;
  endfunction

endpackage

// File: rtl/cmp4_core.sv
// Combinational magnitude compare of a against b.
// The compare is signed when MINMAX_SIGNED_EN is defined, and unsigned otherwise.
module cmp4_core
  import minmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output cmp_t              res
);

`ifdef MINMAX_SIGNED_EN
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s    = $signed(a);
  assign b_s    = $signed(b);
  assign res.eq = (a_s == b_s);
  assign res.gt = (a_s >  b_s);
  assign res.lt = (a_s <  b_s);
`else
  assign res.eq = (a == b);
  assign res.gt = (a >  b);
  assign res.lt = (a <  b);
`endif

endmodule

// File: rtl/minmax_seq_ctrl.sv
// Burst sequencer that tracks the running max and min of a sample stream, together with their indices.
// MINMAX_SIGNED_EN selects a two's-complement compare inside cmp4_core.
module minmax_seq_ctrl
  import minmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic              all_eq,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [CNT_W-1:0]  max_idx,
  output logic [CNT_W-1:0]  min_idx
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic             xfer;
  logic             last;
  cmp_t             cmp_max;
  cmp_t             cmp_min;

  // in_ready is a registered copy of the state decode, so it never depends on in_valid.
  assign xfer = in_valid && in_ready;
  assign last = (cnt == len_q - 1'b1);

  cmp4_core #(.DATA_W(DATA_W)) u_cmp_max (
    .a   (in_data),
    .b   (max_val),
    .res (cmp_max)
  );

  cmp4_core #(.DATA_W(DATA_W)) u_cmp_min (
    .a   (in_data),
    .b   (min_val),
    .res (cmp_min)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      empty    <= 1'b0;
      all_eq   <= 1'b0;
      max_val  <= '0;
      min_val  <= '0;
      max_idx  <= '0;
      min_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (len != '0) begin
              len_q    <= len;
              in_ready <= 1'b1;
              state    <= FIRST;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              empty   <= 1'b1;
              all_eq  <= 1'b0;
              max_val <= '0;
              min_val <= '0;
              max_idx <= '0;
              min_idx <= '0;
            end
          end
        end

        FIRST: begin
          if (xfer) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            all_eq  <= 1'b1;
            empty   <= 1'b0;
            cnt     <= CNT_W'(1);
            if (len_q == CNT_W'(1)) begin
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            // Strict compares: on a tie the earlier index is kept.
            if (cmp_max.gt) begin
              max_val <= in_data;
              max_idx <= cnt;
            end
            if (cmp_min.lt) begin
              min_val <= in_data;
              min_idx <= cnt;
            end
            if (!cmp_max.eq) all_eq <= 1'b0;
            cnt <= cnt + 1'b1;
            if (last) begin
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_seq_ctrl.sv
// Self-checking bench for minmax_seq_ctrl: directed vector table, hand sequences, and random bursts checked against a model.
// The expectations follow the MINMAX_SIGNED_EN build macro.
module tb_minmax_seq_ctrl;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          empty;
  logic          all_eq;
  logic [DW-1:0] max_val;
  logic [DW-1:0] min_val;
  logic [CW-1:0] max_idx;
  logic [CW-1:0] min_idx;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] samp [256];
  int            gap  [256];

  minmax_seq_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .all_eq   (all_eq),
    .max_val  (max_val),
    .min_val  (min_val),
    .max_idx  (max_idx),
    .min_idx  (min_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit greater(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MINMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic check_results(input string tag, input logic [DW-1:0] e_max, input logic [DW-1:0] e_min,
                               input int e_maxi, input int e_mini, input bit e_eq, input bit e_empty);
    check({tag, ".max_val"}, 32'(max_val), 32'(e_max));
    check({tag, ".min_val"}, 32'(min_val), 32'(e_min));
    check({tag, ".max_idx"}, 32'(max_idx), 32'(e_maxi));
    check({tag, ".min_idx"}, 32'(min_idx), 32'(e_mini));
    check({tag, ".all_eq"},  32'(all_eq),  32'(e_eq));
    check({tag, ".empty"},   32'(empty),   32'(e_empty));
  endtask

  // Model: the first strictly-largest and strictly-smallest samples win, and all_eq means every sample matches the first.
  task automatic model_check(input string tag, input int n);
    logic [DW-1:0] mx, mi;
    int mxi, mii;
    bit eq;
    mx = samp[0]; mi = samp[0]; mxi = 0; mii = 0; eq = 1'b1;
    for (int i = 1; i < n; i++) begin
      if (greater(samp[i], mx)) begin mx = samp[i]; mxi = i; end
      if (greater(mi, samp[i])) begin mi = samp[i]; mii = i; end
      if (samp[i] != samp[0]) eq = 1'b0;
    end
    check_results(tag, mx, mi, mxi, mii, eq, 1'b0);
  endtask

  // Starts a burst, streams samp[] with gap[i] idle cycles before sample i, and returns on the negedge where done is expected.
  task automatic run_burst(input string tag, input int n, input bit chk_lat);
    int  cycles = 0;
    int  idx = 0;
    int  wait_left;
    bit  ctrl_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; len = CW'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check({tag, ".empty_done"},  32'(done),     32'd1);
      check({tag, ".empty_ready"}, 32'(in_ready), 32'd0);
      return;
    end
    wait_left = gap[0];
    while (idx < n && cycles < 8 * n + 100) begin
      if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) ctrl_bad = 1'b1;
      if (wait_left > 0) begin
        in_valid = 1'b0;
        wait_left--;
      end else begin
        in_valid = 1'b1;
        in_data  = samp[idx];
      end
      @(negedge clk);
      cycles++;
      if (in_valid) begin
        idx++;
        if (idx < n) wait_left = gap[idx];
      end
    end
    in_valid = 1'b0;
    check({tag, ".all_accepted"}, 32'(idx), 32'(n));
    check({tag, ".ctrl_during_burst"}, 32'(ctrl_bad), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".ready_in_done"}, 32'(in_ready), 32'd0);
    // done occupies the (N+2)th cycle counting the cycle in which start is sampled.
    if (chk_lat) check({tag, ".latency"}, 32'(cycles), 32'(n));
  endtask

  // One cycle after done: the pulse ends, the block is idle, and the results hold.
  task automatic check_after(input string tag);
    logic [DW-1:0] mx, mi;
    mx = max_val; mi = min_val;
    @(negedge clk);
    check({tag, ".done_single"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"},   32'(busy), 32'd0);
    check({tag, ".hold"}, {24'd0, max_val, min_val}, {24'd0, mx, mi});
  endtask

  typedef struct packed {
    logic [7:0] len;
    logic [3:0] s0, s1, s2, s3;
    logic [7:0] gap1;
    logic [3:0] e_max, e_min;
    logic [7:0] e_maxi, e_mini;
    logic       e_eq, e_empty;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;

    vecs[0] = '{len: 4, s0: 3,  s1: 9,  s2: 1,  s3: 9, gap1: 0, e_max: 9,  e_min: 1,  e_maxi: 1, e_mini: 2, e_eq: 0, e_empty: 0};
    vecs[1] = '{len: 3, s0: 15, s1: 15, s2: 15, s3: 0, gap1: 0, e_max: 15, e_min: 15, e_maxi: 0, e_mini: 0, e_eq: 1, e_empty: 0};
    vecs[2] = '{len: 0, s0: 0,  s1: 0,  s2: 0,  s3: 0, gap1: 0, e_max: 0,  e_min: 0,  e_maxi: 0, e_mini: 0, e_eq: 0, e_empty: 1};
    vecs[3] = '{len: 2, s0: 5,  s1: 2,  s2: 0,  s3: 0, gap1: 5, e_max: 5,  e_min: 2,  e_maxi: 0, e_mini: 1, e_eq: 0, e_empty: 0};
`ifdef MINMAX_SIGNED_EN
    vecs[4] = '{len: 3, s0: 7,  s1: 8,  s2: 0,  s3: 0, gap1: 0, e_max: 7,  e_min: 8,  e_maxi: 0, e_mini: 1, e_eq: 0, e_empty: 0};
`else
    vecs[4] = '{len: 3, s0: 7,  s1: 8,  s2: 0,  s3: 0, gap1: 0, e_max: 8,  e_min: 0,  e_maxi: 1, e_mini: 2, e_eq: 0, e_empty: 0};
`endif
    vecs[5] = '{len: 1, s0: 4,  s1: 0,  s2: 0,  s3: 0, gap1: 0, e_max: 4,  e_min: 4,  e_maxi: 0, e_mini: 0, e_eq: 1, e_empty: 0};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.outs", {19'd0, in_ready, busy, done, empty, all_eq, max_val, min_val},
                        32'd0);
    check("reset.idx", {16'd0, max_idx, min_idx}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      samp[0] = vecs[v].s0; samp[1] = vecs[v].s1; samp[2] = vecs[v].s2; samp[3] = vecs[v].s3;
      for (int i = 0; i < 4; i++) gap[i] = 0;
      gap[1] = int'(vecs[v].gap1);
      run_burst(tag, int'(vecs[v].len), vecs[v].gap1 == 0);
      check_results(tag, vecs[v].e_max, vecs[v].e_min, int'(vecs[v].e_maxi), int'(vecs[v].e_mini),
                    vecs[v].e_eq, vecs[v].e_empty);
      check_after(tag);
    end

    // Reset in the middle of a len=5 burst, after two samples.
    begin
      int done_cnt = 0;
      @(negedge clk);
      start = 1'b1; len = 8'd5;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 4'd6;
      @(negedge clk);
      in_data = 4'd11;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.outs", {19'd0, in_ready, busy, done, empty, all_eq, max_val, min_val}, 32'd0);
      check("midrst.idx", {16'd0, max_idx, min_idx}, 32'd0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      check("midrst.no_done", 32'(done_cnt), 32'd0);
      samp[0] = 4'd7; gap[0] = 0;
      run_burst("after_rst", 1, 1'b1);
      check_results("after_rst", 4'd7, 4'd7, 0, 0, 1'b1, 1'b0);
      check_after("after_rst");
    end

    // Random bursts with random valid gaps.
    for (int b = 0; b < 20; b++) begin
      int n;
      string tag;
      n = $urandom_range(1, 12);
      tag = $sformatf("rnd%0d", b);
      for (int i = 0; i < n; i++) begin
        samp[i] = DW'($urandom_range(0, 15));
        gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      run_burst(tag, n, 1'b0);
      model_check(tag, n);
      check_after(tag);
    end

    // Maximum-length burst with its unique largest sample at the last index.
    begin
      logic [DW-1:0] top;
`ifdef MINMAX_SIGNED_EN
      top = 4'd7;
`else
      top = 4'd15;
`endif
      for (int i = 0; i < 255; i++) begin
        samp[i] = DW'($urandom_range(0, 15));
        if (samp[i] == top) samp[i] = 4'd0;
        gap[i] = 0;
      end
      samp[254] = top;
      run_burst("maxlen", 255, 1'b1);
      model_check("maxlen", 255);
      check("maxlen.idx254", 32'(max_idx), 32'd254);
      check_after("maxlen");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
